// File: rtl/oq_header_parser.sv
// Snoops the input-FIFO write stream, decodes each packet's IO-queue header into a
// {dst queue, byte length, word length} descriptor and queues it in a small FWFT FIFO.
module oq_header_parser #(
  parameter int DATA_WIDTH          = 64,
  parameter int CTRL_WIDTH          = DATA_WIDTH / 8,
  parameter int NUM_OUTPUT_QUEUES   = 5,
  parameter int NUM_OQ_WIDTH        = $clog2(NUM_OUTPUT_QUEUES),
  parameter int PKT_LEN_WIDTH       = 11,
  parameter int PKT_WORDS_WIDTH     = PKT_LEN_WIDTH - $clog2(CTRL_WIDTH),
  parameter logic [CTRL_WIDTH-1:0] IOQ_CTRL = 8'hFF,
  parameter int DST_FIFO_DEPTH_BITS = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_wr,
  input  logic [DATA_WIDTH-1:0]      in_data,
  input  logic [CTRL_WIDTH-1:0]      in_ctrl,
  output logic                       in_rdy,
  output logic                       dst_oq_avail,
  output logic [NUM_OQ_WIDTH-1:0]    parsed_dst_oq,
  output logic [PKT_LEN_WIDTH-1:0]   parsed_pkt_byte_len,
  output logic [PKT_WORDS_WIDTH-1:0] parsed_pkt_word_len,
  input  logic                       rd_dst_oq,
  output logic                       hdr_err,
  output logic                       dst_fifo_ovfl,
  output logic [1:0]                 dbg_state
);

  localparam int DEPTH   = 1 << DST_FIFO_DEPTH_BITS;
  localparam int PW      = DST_FIFO_DEPTH_BITS;
  localparam int CW      = DST_FIFO_DEPTH_BITS + 1;
  localparam int ENTRY_W = NUM_OQ_WIDTH + PKT_LEN_WIDTH + PKT_WORDS_WIDTH;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] RDY_MAX  = CW'(DEPTH - 2);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  typedef enum logic [1:0] {
    ST_SOP      = 2'd1,
    ST_WAIT_EOP = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   prev_is_0_q;
  logic   eop;

  logic [NUM_OQ_WIDTH-1:0] dec_idx;
  logic                    dec_found;

  logic               push;
  logic [ENTRY_W-1:0] push_entry;
  logic               hdr_err_d, hdr_err_q;
  logic               ovfl_d, ovfl_q;

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]      count_q, count_d;
  logic               in_rdy_q;
  logic               pop_eff, push_ok;
  logic [ENTRY_W-1:0] head;

  logic unused_hdr_bits;
  assign unused_hdr_bits = ^{in_data[31:PKT_LEN_WIDTH],
                             in_data[47:32+PKT_WORDS_WIDTH],
                             in_data[DATA_WIDTH-1:48+NUM_OUTPUT_QUEUES]};

  // Packet end: first non-zero ctrl after a payload word, same rule as the store stage.
  assign eop = in_wr && (in_ctrl != '0) && prev_is_0_q;

  always_comb begin
    dec_found = 1'b0;
    dec_idx   = '0;
    for (int i = NUM_OUTPUT_QUEUES - 1; i >= 0; i--) begin
      if (in_data[48+i]) begin
        dec_found = 1'b1;
        dec_idx   = NUM_OQ_WIDTH'(i);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    push       = 1'b0;
    push_entry = '0;
    hdr_err_d  = 1'b0;
    case (state_q)
      ST_SOP: begin
        if (in_wr && in_ctrl == IOQ_CTRL) begin
          push       = 1'b1;
          push_entry = {dec_idx, in_data[PKT_LEN_WIDTH-1:0], in_data[32 +: PKT_WORDS_WIDTH]};
          hdr_err_d  = !dec_found;
          state_d    = ST_WAIT_EOP;
        end else if (in_wr && in_ctrl == '0) begin
          // Payload with no header: emit a zero descriptor so descriptors stay 1:1 with packets.
          push      = 1'b1;
          hdr_err_d = 1'b1;
          state_d   = ST_WAIT_EOP;
        end
      end
      ST_WAIT_EOP: begin
        if (eop) state_d = ST_SOP;
      end
      default: state_d = ST_SOP;
    endcase
  end

  assign pop_eff = rd_dst_oq && (count_q != '0);
  assign push_ok = push && ((count_q < FULL_CNT) || pop_eff);
  assign ovfl_d  = push && !push_ok;

  always_comb begin
    count_d = count_q;
    case ({push_ok, pop_eff})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_SOP;
      prev_is_0_q <= 1'b0;
      hdr_err_q   <= 1'b0;
      ovfl_q      <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      in_rdy_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      hdr_err_q <= hdr_err_d;
      ovfl_q    <= ovfl_d;
      count_q   <= count_d;
      in_rdy_q  <= (count_q <= RDY_MAX);
      if (in_wr)   prev_is_0_q <= (in_ctrl == '0);
      if (push_ok) wr_ptr_q    <= wr_ptr_q + PTR_ONE;
      if (pop_eff) rd_ptr_q    <= rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_entry;
  end

  // Head fields read as zero while empty so stale entries never leak out.
  assign head                = dst_oq_avail ? mem_q[rd_ptr_q] : '0;
  assign dst_oq_avail        = (count_q != '0);
  assign parsed_dst_oq       = head[ENTRY_W-1 -: NUM_OQ_WIDTH];
  assign parsed_pkt_byte_len = head[PKT_WORDS_WIDTH +: PKT_LEN_WIDTH];
  assign parsed_pkt_word_len = head[PKT_WORDS_WIDTH-1:0];
  assign in_rdy              = in_rdy_q;
  assign hdr_err             = hdr_err_q;
  assign dst_fifo_ovfl       = ovfl_q;
  assign dbg_state           = state_q;

endmodule

// File: tb/tb_oq_header_parser.sv
// Directed bench for oq_header_parser: expected descriptors are queued when headers are
// driven and compared against the FIFO head when popped.
module tb_oq_header_parser;

  logic         clk;
  logic         reset;
  logic         in_wr;
  logic [63:0]  in_data;
  logic [7:0]   in_ctrl;
  logic         in_rdy;
  logic         dst_oq_avail;
  logic [2:0]   parsed_dst_oq;
  logic [10:0]  parsed_pkt_byte_len;
  logic [7:0]   parsed_pkt_word_len;
  logic         rd_dst_oq;
  logic         hdr_err;
  logic         dst_fifo_ovfl;
  logic [1:0]   dbg_state;

  typedef logic [21:0] desc_t;
  desc_t exp_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  oq_header_parser dut (
    .clk                 (clk),
    .reset               (reset),
    .in_wr               (in_wr),
    .in_data             (in_data),
    .in_ctrl             (in_ctrl),
    .in_rdy              (in_rdy),
    .dst_oq_avail        (dst_oq_avail),
    .parsed_dst_oq       (parsed_dst_oq),
    .parsed_pkt_byte_len (parsed_pkt_byte_len),
    .parsed_pkt_word_len (parsed_pkt_word_len),
    .rd_dst_oq           (rd_dst_oq),
    .hdr_err             (hdr_err),
    .dst_fifo_ovfl       (dst_fifo_ovfl),
    .dbg_state           (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    in_wr     = 1'b0;
    in_ctrl   = '0;
    in_data   = '0;
    rd_dst_oq = 1'b0;
    reset     = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
  endtask

  // Reference decode of a header into the expected descriptor
  function automatic desc_t mk_desc(logic [15:0] dst, logic [15:0] words, logic [15:0] bytes);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 4; i >= 0; i--) if (dst[i]) idx = 3'(i);
    return {idx, bytes[10:0], words[7:0]};
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_head(string tag);
    desc_t d;
    if (exp_q.size() == 0) begin
      check({tag, "_avail0"}, 32'(dst_oq_avail), 32'd0);
    end else begin
      d = exp_q[0];
      check({tag, "_avail"}, 32'(dst_oq_avail), 32'd1);
      check({tag, "_dst"},   32'(parsed_dst_oq),       32'(d[21:19]));
      check({tag, "_bytes"}, 32'(parsed_pkt_byte_len), 32'(d[18:8]));
      check({tag, "_words"}, 32'(parsed_pkt_word_len), 32'(d[7:0]));
    end
  endtask

  // Driver tasks: inputs change on the falling edge, outputs are read on the next one
  task automatic word(logic [7:0] ctrl, logic [63:0] data, logic rd);
    in_wr     = 1'b1;
    in_ctrl   = ctrl;
    in_data   = data;
    rd_dst_oq = rd;
    @(negedge clk);
    in_wr     = 1'b0;
    in_ctrl   = '0;
    in_data   = '0;
    rd_dst_oq = 1'b0;
  endtask

  task automatic pop_check(string tag);
    check_head(tag);
    rd_dst_oq = 1'b1;
    @(negedge clk);
    rd_dst_oq = 1'b0;
    if (exp_q.size() > 0) void'(exp_q.pop_front());
  endtask

  task automatic send_header(string tag, logic [15:0] dst, logic [15:0] words,
                             logic [15:0] bytes, logic rd);
    logic exp_ovfl;
    if (rd && exp_q.size() > 0) void'(exp_q.pop_front());
    exp_ovfl = (exp_q.size() >= 4);
    if (!exp_ovfl) exp_q.push_back(mk_desc(dst, words, bytes));
    word(8'hFF, {dst, words, 16'h5A5A, bytes}, rd);
    check({tag, "_hdr_err"}, 32'(hdr_err), 32'(dst[4:0] == 5'd0));
    check({tag, "_ovfl"},    32'(dst_fifo_ovfl), 32'(exp_ovfl));
    check_head({tag, "_head"});
  endtask

  task automatic send_payload(int n);
    for (int i = 0; i < n; i++)
      word((i == n - 1) ? 8'h40 : 8'h00, {$urandom, $urandom}, 1'b0);
  endtask

  task automatic send_pkt(string tag, logic [15:0] dst, logic [15:0] words,
                          logic [15:0] bytes, int npay);
    send_header(tag, dst, words, bytes, 1'b0);
    send_payload(npay);
    check({tag, "_state_sop"}, 32'(dbg_state), 32'd1);
  endtask

  initial begin
    do_reset();

    // Reset state
    check("rst_in_rdy", 32'(in_rdy), 32'd1);
    check("rst_avail",  32'(dst_oq_avail), 32'd0);
    check("rst_dst",    32'(parsed_dst_oq), 32'd0);
    check("rst_bytes",  32'(parsed_pkt_byte_len), 32'd0);
    check("rst_words",  32'(parsed_pkt_word_len), 32'd0);
    check("rst_hdr_err", 32'(hdr_err), 32'd0);
    check("rst_ovfl",   32'(dst_fifo_ovfl), 32'd0);
    check("rst_state",  32'(dbg_state), 32'd1);

    // Single packet
    send_pkt("single", 16'h0004, 16'd9, 16'd70, 9);
    pop_check("single_pop");
    check_head("single_empty");

    // Five back-to-back packets, no pops: fifth overflows
    for (int k = 0; k < 5; k++) begin
      send_pkt($sformatf("b2b%0d", k), 16'(1 << k), 16'(4 + k), 16'(100 + k), 2);
      check($sformatf("b2b%0d_in_rdy", k), 32'(in_rdy), 32'(exp_q.size() <= 2));
    end
    for (int k = 0; k < 4; k++) pop_check($sformatf("b2b_pop%0d", k));
    repeat (1) @(negedge clk);
    check_head("b2b_empty");
    check("b2b_in_rdy_back", 32'(in_rdy), 32'd1);

    // Destination decode corners and length truncation
    send_pkt("dst_none", 16'h0000, 16'd3, 16'd20, 2);
    send_pkt("dst_multi", 16'h0006, 16'd3, 16'd20, 2);
    send_pkt("trunc", 16'hFFE0 | 16'h0010, 16'h01FF, 16'hFFFF, 2);
    pop_check("dst_none_pop");
    pop_check("dst_multi_pop");
    pop_check("trunc_pop");

    // Pop while empty is ignored
    rd_dst_oq = 1'b1;
    @(negedge clk);
    rd_dst_oq = 1'b0;
    @(negedge clk);
    check_head("empty_rd");
    check("empty_rd_in_rdy", 32'(in_rdy), 32'd1);

    // Second IOQ header inside a packet is ignored
    send_header("dup_hdr", 16'h0002, 16'd6, 16'd44, 1'b0);
    word(8'hFF, {16'h0008, 16'd1, 16'h0, 16'd8}, 1'b0);
    check("dup_hdr2_ovfl", 32'(dst_fifo_ovfl), 32'd0);
    check_head("dup_hdr2_head");
    send_payload(3);
    pop_check("dup_pop");
    check_head("dup_empty");

    // Full FIFO with push and pop on the same edge
    for (int k = 0; k < 4; k++) send_pkt($sformatf("full%0d", k), 16'(1 << k), 16'(10 + k), 16'(200 + k), 2);
    check("full_in_rdy", 32'(in_rdy), 32'd0);
    send_header("pushpop", 16'h0010, 16'd7, 16'd55, 1'b1);
    send_payload(2);
    check("pushpop_in_rdy", 32'(in_rdy), 32'd0);
    for (int k = 0; k < 4; k++) pop_check($sformatf("pushpop_pop%0d", k));
    check_head("pushpop_empty");

    // Payload with no header seen: zero descriptor and error pulse
    exp_q.push_back(22'd0);
    word(8'h00, 64'hDEAD_BEEF_0000_1111, 1'b0);
    check("nohdr_hdr_err", 32'(hdr_err), 32'd1);
    check_head("nohdr_head");
    send_payload(1);
    check("nohdr_state_sop", 32'(dbg_state), 32'd1);
    pop_check("nohdr_pop");

    // Reset in the middle of a packet's payload
    send_header("midrst", 16'h0008, 16'd12, 16'd90, 1'b0);
    for (int i = 0; i < 3; i++) word(8'h00, {$urandom, $urandom}, 1'b0);
    do_reset();
    check_head("midrst_after");
    check("midrst_state", 32'(dbg_state), 32'd1);
    check("midrst_in_rdy", 32'(in_rdy), 32'd1);
    send_pkt("midrst_new", 16'h0002, 16'd5, 16'd33, 4);
    pop_check("midrst_pop");
    check_head("midrst_empty");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
